// File: rtl/seg7_pkg.sv
// Shared seven-segment constants (active-low, bit order g..a) and the
// converter state encoding used by bin2bcd_display.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

endpackage

// File: rtl/bin2bcd_display_if.sv
// Request/result bundle between the binary source and bin2bcd_display.
interface bin2bcd_display_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);

  logic                  Start;
  logic [WIDTH-1:0]      Value;
  logic                  Busy;
  logic                  Done;
  logic                  Ovf;
  logic [7*DIGITS-1:0]   HEX;

  modport master (
    output Start, Value,
    input  Busy, Done, Ovf, HEX
  );

  modport slave (
    input  Start, Value,
    output Busy, Done, Ovf, HEX
  );

endinterface

// File: rtl/seg7_digit.sv
// Combinational BCD to active-low seven-segment decoder with blanking.
module seg7_digit
  import seg7_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    if (i_blank) begin
      o_seg = SEG_BLANK;
    end else begin
      case (i_bcd)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bin2bcd_display.sv
// Sequential double-dabble binary-to-BCD converter driving DIGITS seven-segment
// displays. Define BIN2BCD_BLANK_EN to blank leading zero digits.
module bin2bcd_display
  import seg7_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic             Clock,
  input  logic             Reset,
  bin2bcd_display_if.slave bus
);

  localparam int                BCD_W   = 4 * DIGITS;
  localparam int                CNT_W   = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_IT = CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_ovf;
  logic [BCD_W-1:0]   r_disp;

  logic [WIDTH-1:0]   r_shift;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_ovf_acc;

  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_bcd_nxt;
  logic               w_ovf_nxt;
  logic [DIGITS-1:0]  w_blank;
  logic [7*DIGITS-1:0] w_hex;

  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return res;
  endfunction

  // A set bit 3 in the top digit after add-3 would be shifted out of the register.
  assign w_adj     = add3_digits(r_bcd);
  assign w_bcd_nxt = {w_adj[BCD_W-2:0], r_shift[WIDTH-1]};
  assign w_ovf_nxt = r_ovf_acc | w_adj[BCD_W-1];

  // Datapath: operand capture in IDLE, one shift-and-add-3 step per CONV cycle
  always_ff @(posedge Clock) begin
    if (r_state == IDLE) begin
      if (bus.Start) begin
        r_shift   <= bus.Value;
        r_bcd     <= '0;
        r_ovf_acc <= 1'b0;
      end
    end else begin
      r_shift   <= r_shift << 1;
      r_bcd     <= w_bcd_nxt;
      r_ovf_acc <= w_ovf_nxt;
    end
  end

  // Control FSM and display register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_disp  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.Start) begin
            r_state <= CONV;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        CONV: begin
          if (r_cnt == LAST_IT) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_disp  <= w_bcd_nxt;
            r_ovf   <= w_ovf_nxt;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef BIN2BCD_BLANK_EN
  logic w_upper_zero;

  // Digit 0 is never blanked; a dash display overrides blanking.
  always_comb begin
    w_blank      = '0;
    w_upper_zero = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      w_upper_zero = w_upper_zero && (r_disp[4*i +: 4] == 4'd0);
      w_blank[i]   = w_upper_zero && !r_ovf;
    end
  end
`else
  assign w_blank = '0;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    logic [6:0] w_seg;

    seg7_digit u_digit (
      .i_bcd   (r_disp[4*g +: 4]),
      .i_blank (w_blank[g]),
      .o_seg   (w_seg)
    );

    assign w_hex[7*g +: 7] = r_ovf ? SEG_DASH : w_seg;
  end

  assign bus.Busy = r_busy;
  assign bus.Done = r_done;
  assign bus.Ovf  = r_ovf;
  assign bus.HEX  = w_hex;

endmodule

// File: tb/tb_bin2bcd_display.sv
// Directed bench for bin2bcd_display: a 3-digit and a 2-digit instance,
// WIDTH=8, hand-computed digit expectations.
module tb_bin2bcd_display;

  localparam int W = 8;
  localparam logic [6:0] BLK  = 7'b1111111;
  localparam logic [6:0] DASH = 7'b0111111;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  always #5 Clock = ~Clock;

  bin2bcd_display_if #(.WIDTH(W), .DIGITS(3)) bus3 ();
  bin2bcd_display_if #(.WIDTH(W), .DIGITS(2)) bus2 ();

  bin2bcd_display #(.WIDTH(W), .DIGITS(3)) u_dut3 (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus3.slave)
  );

  bin2bcd_display #(.WIDTH(W), .DIGITS(2)) u_dut2 (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus2.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  int          busy_n;
  int          done_n;
  int          busy_done_n;
  int          d_idx [4];
  logic [20:0] d_hex [4];
  logic        d_ovf [4];

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return DASH;
    endcase
  endfunction

  function automatic logic [20:0] hex3(input int d2, input int d1, input int d0);
    logic [6:0] s2;
    logic [6:0] s1;
    s2 = seg(d2);
    s1 = seg(d1);
`ifdef BIN2BCD_BLANK_EN
    if (d2 == 0) begin
      s2 = BLK;
      if (d1 == 0) s1 = BLK;
    end
`endif
    return {s2, s1, seg(d0)};
  endfunction

  function automatic logic [20:0] hex2(input int d1, input int d0);
    logic [6:0] s1;
    s1 = seg(d1);
`ifdef BIN2BCD_BLANK_EN
    if (d1 == 0) s1 = BLK;
`endif
    return {7'b0, s1, seg(d0)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input bit sel, input bit st, input int v);
    if (sel) begin
      bus2.Start = st;
      bus2.Value = W'(v);
    end else begin
      bus3.Start = st;
      bus3.Value = W'(v);
    end
  endtask

  task automatic clear_stats();
    busy_n      = 0;
    done_n      = 0;
    busy_done_n = 0;
    for (int k = 0; k < 4; k++) begin
      d_idx[k] = -1;
      d_hex[k] = 'x;
      d_ovf[k] = 1'bx;
    end
  endtask

  task automatic sample(input bit sel, input int j);
    logic        b;
    logic        d;
    logic        o;
    logic [20:0] h;
    if (sel) begin
      b = bus2.Busy; d = bus2.Done; o = bus2.Ovf; h = {7'b0, bus2.HEX};
    end else begin
      b = bus3.Busy; d = bus3.Done; o = bus3.Ovf; h = bus3.HEX;
    end
    if (b) busy_n++;
    if (d) begin
      if (b) busy_done_n++;
      if (done_n < 4) begin
        d_idx[done_n] = j;
        d_hex[done_n] = h;
        d_ovf[done_n] = o;
      end
      done_n++;
    end
  endtask

  // Start pulse on the current falling edge; sample j is taken after edge E_j.
  task automatic run(input bit sel, input int v, input int win, input int inj_at, input int inj_v);
    clear_stats();
    drv(sel, 1'b1, v);
    @(posedge Clock);
    @(negedge Clock);
    for (int j = 0; j < win; j++) begin
      drv(sel, (j == inj_at), (inj_at >= 0 && j >= inj_at) ? inj_v : v);
      sample(sel, j);
      @(posedge Clock);
      @(negedge Clock);
    end
    drv(sel, 1'b0, 0);
  endtask

  initial begin
    bus3.Start = 1'b0; bus3.Value = '0;
    bus2.Start = 1'b0; bus2.Value = '0;
    Reset = 1'b1;
    repeat (2) @(negedge Clock);

    chk("rst_busy", 32'(bus3.Busy), 32'd0);
    chk("rst_done", 32'(bus3.Done), 32'd0);
    chk("rst_ovf",  32'(bus3.Ovf),  32'd0);
    chk("rst_hex3", 32'(bus3.HEX),  32'(hex3(0, 0, 0)));
    chk("rst_hex2", 32'({7'b0, bus2.HEX}), 32'(hex2(0, 0)));
    Reset = 1'b0;
    @(negedge Clock);
    chk("idle_busy", 32'(bus3.Busy), 32'd0);

    // 255 on three digits
    run(1'b0, 255, 12, -1, 0);
    chk("v255_busy_cycles", 32'(busy_n), 32'd8);
    chk("v255_done_count",  32'(done_n), 32'd1);
    chk("v255_latency",     32'(d_idx[0]), 32'd8);
    chk("v255_busy_in_done", 32'(busy_done_n), 32'd0);
    chk("v255_hex",         32'(d_hex[0]), 32'(hex3(2, 5, 5)));
    chk("v255_ovf",         32'(d_ovf[0]), 32'd0);
    chk("v255_hold",        32'(bus3.HEX), 32'(hex3(2, 5, 5)));

    run(1'b0, 7, 12, -1, 0);
    chk("v7_hex", 32'(d_hex[0]), 32'(hex3(0, 0, 7)));
    chk("v7_ovf", 32'(d_ovf[0]), 32'd0);

    run(1'b0, 0, 12, -1, 0);
    chk("v0_hex", 32'(d_hex[0]), 32'(hex3(0, 0, 0)));

    // second Start during CONV must be ignored
    run(1'b0, 42, 14, 2, 13);
    chk("v42_done_count", 32'(done_n), 32'd1);
    chk("v42_latency",    32'(d_idx[0]), 32'd8);
    chk("v42_hex",        32'(d_hex[0]), 32'(hex3(0, 4, 2)));
    chk("v42_hold",       32'(bus3.HEX), 32'(hex3(0, 4, 2)));

    // two-digit overflow then recovery
    run(1'b1, 100, 12, -1, 0);
    chk("v100_ovf", 32'(d_ovf[0]), 32'd1);
    chk("v100_hex", 32'(d_hex[0]), 32'({7'b0, DASH, DASH}));
    run(1'b1, 99, 12, -1, 0);
    chk("v99_ovf", 32'(d_ovf[0]), 32'd0);
    chk("v99_hex", 32'(d_hex[0]), 32'(hex2(9, 9)));
    run(1'b1, 5, 12, -1, 0);
    chk("v5_hex2", 32'(d_hex[0]), 32'(hex2(0, 5)));

    // Start held high: 128 then 64, Value changes mid-CONV
    clear_stats();
    drv(1'b0, 1'b1, 128);
    @(posedge Clock);
    @(negedge Clock);
    for (int j = 0; j < 22; j++) begin
      drv(1'b0, (j < 17), 64);
      sample(1'b0, j);
      @(posedge Clock);
      @(negedge Clock);
    end
    drv(1'b0, 1'b0, 0);
    chk("b2b_done_count", 32'(done_n), 32'd2);
    chk("b2b_first_idx",  32'(d_idx[0]), 32'd8);
    chk("b2b_second_idx", 32'(d_idx[1]), 32'd17);
    chk("b2b_first_hex",  32'(d_hex[0]), 32'(hex3(1, 2, 8)));
    chk("b2b_second_hex", 32'(d_hex[1]), 32'(hex3(0, 6, 4)));
    chk("b2b_busy_cycles", 32'(busy_n), 32'd16);

    // reset in the middle of a 255 conversion
    clear_stats();
    drv(1'b0, 1'b1, 255);
    @(posedge Clock);
    @(negedge Clock);
    for (int j = 0; j < 4; j++) begin
      drv(1'b0, 1'b0, 255);
      @(posedge Clock);
      @(negedge Clock);
    end
    chk("mid_busy", 32'(bus3.Busy), 32'd1);
    Reset = 1'b1;
    #1;
    chk("arst_busy", 32'(bus3.Busy), 32'd0);
    chk("arst_done", 32'(bus3.Done), 32'd0);
    chk("arst_ovf",  32'(bus3.Ovf),  32'd0);
    chk("arst_hex3", 32'(bus3.HEX),  32'(hex3(0, 0, 0)));
    chk("arst_hex2", 32'({7'b0, bus2.HEX}), 32'(hex2(0, 0)));
    @(negedge Clock);
    Reset = 1'b0;
    clear_stats();
    for (int j = 0; j < 12; j++) begin
      sample(1'b0, j);
      @(posedge Clock);
      @(negedge Clock);
    end
    chk("post_rst_done", 32'(done_n), 32'd0);
    chk("post_rst_busy", 32'(busy_n), 32'd0);
    chk("post_rst_hex",  32'(bus3.HEX), 32'(hex3(0, 0, 0)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bin2bcd_display.md
# bin2bcd_display

Sequential binary-to-decimal display driver: accepts an unsigned binary value on a start strobe, converts it to BCD with a shift-and-add-3 (double-dabble) engine at one bit per clock, and drives `DIGITS` active-low seven-segment displays. It is the parametrised, clocked successor to the single-digit combinational decoder, intended to sit between switch/counter logic and the board's HEX display bank.

## Interface
- `WIDTH`, 8: bit width of the binary input (≥1).
- `DIGITS`, 3: number of decimal digits/displays driven (≥1).
- `Clock`  input  1  rising-edge system clock.
- `Reset`  input  1  asynchronous, active-high reset.
- `Start`  input  1  request conversion of `Value`; sampled only in IDLE.
- `Value`  input  WIDTH  unsigned binary operand; captured on accepted `Start`.
- `Busy`  output  1  high while a conversion is in progress.
- `Done`  output  1  one-cycle pulse when a new result is displayed.
- `Ovf`  output  1  result does not fit in DIGITS decimal digits.
- `HEX`  output  7*DIGITS  segments; `HEX[7*i+k]` is segment k (k=0 is a … k=6 is g) of digit i (i=0 least significant); active-low.

## Operation
- States: IDLE, CONV.
- IDLE: on an edge with `Start`=1, capture `Value` into the shift register, clear the working BCD register and the overflow flag, zero the iteration counter, and go to CONV.
- CONV: each edge performs one iteration: every BCD digit ≥5 gets +3, then {BCD, shift} shifts left by one. After the WIDTH-th iteration, load the display register and `Ovf`, pulse `Done`, and return to IDLE.
- Overflow: if bit 3 of the most significant digit (after add-3) is 1 at any iteration, set the sticky flag. At completion with the flag set: `Ovf`=1 and every digit shows a dash (only g lit: g..a = 0111111).
- `Start` in CONV is ignored; there is no queueing. `Value` changes during CONV have no effect.
- The display register holds the last result until the next completion. `HEX` is a combinational decode of the display register.
- Digit codes (g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Reset (any time, including mid-CONV): state IDLE, counter 0, `Busy`=0, `Done`=0, `Ovf`=0, display register all-zero BCD. Any in-flight conversion is discarded.

## Timing
- Accepting edge E0, then iterations on edges E1…E_WIDTH.
- `Busy`=1 from after E0 through E_WIDTH. `Done`=1 for exactly the cycle after E_WIDTH, and `Busy`=0 in that same cycle.
- `HEX` and `Ovf` update after E_WIDTH, so latency is WIDTH clocks from the accepting edge.
- `Start` high in the `Done` cycle is accepted (back-to-back throughput is WIDTH+1 clocks per conversion).
- The counter width is $clog2(WIDTH+1).

## Configuration
- `BIN2BCD_BLANK_EN` defined:
  - Leading-zero blanking applies: any digit above the most significant non-zero digit is blank (1111111).
  - Digit 0 is never blanked, so 0 shows a single "0".
  - Blanking does not apply when `Ovf`=1.
- `BIN2BCD_BLANK_EN` undefined: all DIGITS digits are always shown, including leading zeros.
- Reset display: "0" plus blanks when defined; all zeros when undefined.

## Structure
- Shared package `seg7_pkg` holds:
  - the 7-bit segment codes for 0–9;
  - the `SEG_BLANK` and `SEG_DASH` constants;
  - the state enum `{IDLE, CONV}`.
- One sub-module `seg7_digit`: combinational 4-bit BCD to active-low 7-segment decoder with a blank input, instantiated DIGITS times through a generate loop.
- Non-BCD codes (10–15) decode to `SEG_DASH`; they cannot occur in normal operation.

## Test plan
- WIDTH=8, DIGITS=3, `Value`=255, `Start` pulse → `Busy` high for 8 cycles, `Done` pulses once, `HEX` shows 2,5,5 (digit2..0), `Ovf`=0.
- WIDTH=8, DIGITS=3, `Value`=7 with `BIN2BCD_BLANK_EN` → digits 2 and 1 = 1111111, digit0 = 1111000. Without the macro → 0,0,7.
- WIDTH=8, DIGITS=2, `Value`=100 → `Ovf`=1, both digits 0111111. A following `Value`=99 → `Ovf`=0, shows 9,9.
- `Start` with `Value`=42, then `Start` with `Value`=13 at cycle 3 of CONV → only 42 is displayed, exactly one `Done` pulse.
- `Reset` asserted at cycle 4 of a 255 conversion → `Busy`, `Done`, `Ovf` immediately 0, display reset value, no `Done` afterwards.
- `Start` held high continuously with `Value`=128 then 64 → conversions every 9 clocks, `Done` pulses 9 clocks apart, display 1,2,8 then 0,6,4 (or blank,6,4).
